cache_line_fill_ctrl: RTL

Parametrised miss handler between the L1 data cache and the shared L2 bus. On a read or write miss it writes back the dirty victim line if there is one, then fetches the missing line beat by beat. For a write miss it merges the store word into the fetched line. It then issues a single-cycle update of the cache entry: data, tag, valid and dirty.

---
 rtl/cache_line_fill_ctrl_pkg.sv | 25 ++
 rtl/cache_line_fill_ctrl_line_buffer.sv | 37 +++
 rtl/cache_line_fill_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_fill_ctrl_pkg.sv
// Shared types and helpers for the L1 miss handler: FSM states, default widths
// and the L2 word-address formation used for both write-back and fill beats.
package cache_pkg;

   localparam int unsigned DEF_ADDR_W         = 32;
   localparam int unsigned DEF_DATA_W         = 32;
   localparam int unsigned DEF_WORDS_PER_LINE = 8;
   localparam int unsigned DEF_TAG_W          = 18;

   typedef enum logic [1:0] {
      IDLE,
      WB,
      FILL,
      UPD
   } state_e;

   // Word address = {bw zeros, line index, beat}; byte address held LSB-aligned in 64 bits.
   function automatic logic [63:0] word_addr(input logic [63:0]   line_addr,
                                             input int unsigned   beat,
                                             input int unsigned   off_w,
                                             input int unsigned   bw);
      return ((line_addr >> (off_w + bw)) << off_w) | 64'(beat);
   endfunction

endpackage

// File: rtl/cache_line_fill_ctrl_line_buffer.sv
// Fill-line storage: one word written per received beat, with the store word
// substituted at the merge slot. Exposes the line as it will be after this cycle.
module line_buffer #(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned WORDS_PER_LINE = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               wr_en_i,
   input  logic [$clog2(WORDS_PER_LINE)-1:0]  wr_idx_i,
   input  logic [DATA_W-1:0]                  rd_data_i,
   input  logic                               merge_i,
   input  logic [DATA_W-1:0]                  merge_data_i,
   output logic [DATA_W*WORDS_PER_LINE-1:0]   line_nxt_o
);

   logic [DATA_W*WORDS_PER_LINE-1:0] line_q;
   logic [DATA_W*WORDS_PER_LINE-1:0] line_d;

   always_comb begin
      line_d = line_q;
      if (wr_en_i) begin
         line_d[wr_idx_i*DATA_W +: DATA_W] = merge_i ? merge_data_i : rd_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q <= '0;
      end else begin
         line_q <= line_d;
      end
   end

   assign line_nxt_o = line_d;

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// L1 miss handler: optional dirty-victim write-back, beat-by-beat line fill with
// store merge, then a single-cycle cache entry update. All outputs are registered.
module cache_line_fill_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W         = DEF_ADDR_W,
   parameter int unsigned DATA_W         = DEF_DATA_W,
   parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
   parameter int unsigned TAG_W          = DEF_TAG_W
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              miss_req,
   input  logic                              miss_is_wr,
   input  logic [ADDR_W-1:0]                 miss_addr,
   input  logic [DATA_W-1:0]                 miss_wr_data,
   input  logic                              victim_dirty,
   input  logic [ADDR_W-1:0]                 victim_addr,
   input  logic [DATA_W*WORDS_PER_LINE-1:0]  victim_line,
   output logic                              busy,
   output logic                              miss_done,
   output logic [ADDR_W-1:0]                 l2_addr,
   output logic                              l2_rd_en,
   input  logic                              l2_rd_granted,
   input  logic                              l2_rd_vld,
   input  logic [DATA_W-1:0]                 l2_rd_data,
   output logic                              l2_wr_en,
   input  logic                              l2_wr_granted,
   output logic [DATA_W-1:0]                 l2_wr_data,
   output logic                              upd_entry,
   output logic [DATA_W*WORDS_PER_LINE-1:0]  upd_line,
   output logic [TAG_W:0]                    upd_tag_vld,
   output logic                              upd_dirty
);

   localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
   localparam int unsigned BW     = $clog2(DATA_W / 8);
   localparam int unsigned CW     = OFF_W + 1;
   localparam int unsigned LINE_W = DATA_W * WORDS_PER_LINE;
   localparam logic [CW-1:0] CNT_LAST = CW'(WORDS_PER_LINE - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WORDS_PER_LINE);

   state_e              state_q, state_d;
   logic [CW-1:0]       wb_cnt_q, wb_cnt_d;
   logic [CW-1:0]       iss_cnt_q, iss_cnt_d;
   logic [CW-1:0]       rcv_cnt_q, rcv_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                is_wr_q, is_wr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [ADDR_W-1:0]   vaddr_q, vaddr_d;
   logic [LINE_W-1:0]   vline_q, vline_d;

   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d;
   logic                rd_en_q, rd_en_d;
   logic                wr_en_q, wr_en_d;
   logic [DATA_W-1:0]   wr_out_q, wr_out_d;
   logic [LINE_W-1:0]   upd_line_q, upd_line_d;
   logic [TAG_W:0]      tag_vld_q, tag_vld_d;
   logic                dirty_q, dirty_d;

   logic                buf_wr;
   logic                buf_merge;
   logic [LINE_W-1:0]   line_nxt;

   line_buffer #(
      .DATA_W         (DATA_W),
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_line_buffer (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en_i      (buf_wr),
      .wr_idx_i     (rcv_cnt_q[OFF_W-1:0]),
      .rd_data_i    (l2_rd_data),
      .merge_i      (buf_merge),
      .merge_data_i (wr_data_q),
      .line_nxt_o   (line_nxt)
   );

   always_comb begin
      state_d   = state_q;
      wb_cnt_d  = wb_cnt_q;
      iss_cnt_d = iss_cnt_q;
      rcv_cnt_d = rcv_cnt_q;
      addr_d    = addr_q;
      is_wr_d   = is_wr_q;
      wr_data_d = wr_data_q;
      vaddr_d   = vaddr_q;
      vline_d   = vline_q;
      buf_wr    = 1'b0;
      buf_merge = is_wr_q && (rcv_cnt_q[OFF_W-1:0] == addr_q[OFF_W+BW-1:BW]);

      unique case (state_q)
         IDLE: begin
            if (miss_req) begin
               addr_d    = miss_addr;
               is_wr_d   = miss_is_wr;
               wr_data_d = miss_wr_data;
               vaddr_d   = victim_addr;
               vline_d   = victim_line;
               wb_cnt_d  = '0;
               iss_cnt_d = '0;
               rcv_cnt_d = '0;
               state_d   = victim_dirty ? WB : FILL;
            end
         end
         WB: begin
            if (l2_wr_granted) begin
               wb_cnt_d = wb_cnt_q + CW'(1);
               if (wb_cnt_q == CNT_LAST) state_d = FILL;
            end
         end
         FILL: begin
            if (rd_en_q && l2_rd_granted) iss_cnt_d = iss_cnt_q + CW'(1);
            // A beat is only accepted when one is outstanding.
            if (l2_rd_vld && (rcv_cnt_q != iss_cnt_q)) begin
               buf_wr    = 1'b1;
               rcv_cnt_d = rcv_cnt_q + CW'(1);
               if (rcv_cnt_q == CNT_LAST) state_d = UPD;
            end
         end
         UPD:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Registered outputs are computed from next-state values.
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == UPD);
      wr_en_d    = (state_d == WB);
      rd_en_d    = (state_d == FILL) && (iss_cnt_d < CNT_FULL);
      l2_addr_d  = l2_addr_q;
      wr_out_d   = wr_out_q;
      upd_line_d = upd_line_q;
      tag_vld_d  = tag_vld_q;
      dirty_d    = dirty_q;
      if (wr_en_d) begin
         l2_addr_d = ADDR_W'(word_addr(64'(vaddr_d), 32'(wb_cnt_d[OFF_W-1:0]), OFF_W, BW));
         wr_out_d  = vline_d[wb_cnt_d[OFF_W-1:0]*DATA_W +: DATA_W];
      end else if (rd_en_d) begin
         l2_addr_d = ADDR_W'(word_addr(64'(addr_d), 32'(iss_cnt_d[OFF_W-1:0]), OFF_W, BW));
      end
      if (done_d) begin
         upd_line_d = line_nxt;
         tag_vld_d  = {1'b1, addr_d[ADDR_W-1 -: TAG_W]};
         dirty_d    = is_wr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wb_cnt_q   <= '0;
         iss_cnt_q  <= '0;
         rcv_cnt_q  <= '0;
         addr_q     <= '0;
         is_wr_q    <= 1'b0;
         wr_data_q  <= '0;
         vaddr_q    <= '0;
         vline_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         l2_addr_q  <= '0;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_out_q   <= '0;
         upd_line_q <= '0;
         tag_vld_q  <= '0;
         dirty_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wb_cnt_q   <= wb_cnt_d;
         iss_cnt_q  <= iss_cnt_d;
         rcv_cnt_q  <= rcv_cnt_d;
         addr_q     <= addr_d;
         is_wr_q    <= is_wr_d;
         wr_data_q  <= wr_data_d;
         vaddr_q    <= vaddr_d;
         vline_q    <= vline_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         l2_addr_q  <= l2_addr_d;
         rd_en_q    <= rd_en_d;
         wr_en_q    <= wr_en_d;
         wr_out_q   <= wr_out_d;
         upd_line_q <= upd_line_d;
         tag_vld_q  <= tag_vld_d;
         dirty_q    <= dirty_d;
      end
   end

   assign busy        = busy_q;
   assign miss_done   = done_q;
   assign l2_addr     = l2_addr_q;
   assign l2_rd_en    = rd_en_q;
   assign l2_wr_en    = wr_en_q;
   assign l2_wr_data  = wr_out_q;
   assign upd_entry   = done_q;
   assign upd_line    = upd_line_q;
   assign upd_tag_vld = tag_vld_q;
   assign upd_dirty   = dirty_q;

endmodule
